adder_scheduler: RTL and testbench

ADDER_SCHEDULER -- requirements
Module: adder_scheduler

---
 rtl/adder_sched_pkg.sv | 12 +
 rtl/full_adder_14bit.sv | 12 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/adder_scheduler.sv | 150 +++++++++++++++
 tb/tb_adder_scheduler.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the round-robin adder scheduler.
package adder_sched_pkg;

  localparam int DATA_W = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_14bit.sv
// 14-bit adder with carry-in and carry-out.
module full_adder_14bit (
  input  logic [13:0] a,
  input  logic [13:0] b,
  input  logic        cin,
  output logic [13:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {14'd0, cin};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin winner selection: first high request at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [IDW-1:0]  winner,
  output logic            any_req
);

  logic [IDW:0] cand_s;
  logic         found_s;

  // Walk the requesters in rotated order; the extra bit keeps ptr+offset from overflowing.
  always_comb begin
    winner  = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand_s = {1'b0, rr_ptr} + (IDW+1)'(off);
      if (cand_s >= (IDW+1)'(NREQ)) begin
        cand_s = cand_s - (IDW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s[IDW-1:0]]) begin
        winner  = cand_s[IDW-1:0];
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/adder_scheduler.sv
// Shares one 14-bit adder among NREQ requesters: IDLE latches the round-robin
// winner's operands, ADD registers the result, RESP pulses that requester's ack.
module adder_scheduler
  import adder_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   a,
  input  logic [NREQ*DATA_W-1:0]   b,
  input  logic [NREQ-1:0]          cin,
  output logic [NREQ-1:0]          ack,
  output logic [DATA_W-1:0]        sum,
  output logic                     cout,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic                cin_q, cin_d;
  logic [IDW-1:0]      grant_q, grant_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                cout_q, cout_d;

  logic [IDW-1:0]      winner_s;
  logic                any_req_s;
  logic [DATA_W-1:0]   add_sum_s;
  logic                add_cout_s;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .winner  (winner_s),
    .any_req (any_req_s)
  );

  // The adder only ever sees latched operands, so late input changes cannot leak in.
  full_adder_14bit u_add (
    .a    (a_q),
    .b    (b_q),
    .cin  (cin_q),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      ADD:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: operand latch, result capture, pointer advance.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          a_d     = a[winner_s*DATA_W +: DATA_W];
          b_d     = b[winner_s*DATA_W +: DATA_W];
          cin_d   = cin[winner_s];
          grant_d = winner_s;
        end else begin
          grant_d = grant_q;
        end
      end
      ADD: begin
        sum_d  = add_sum_s;
        cout_d = add_cout_s;
      end
      RESP: begin
        if (grant_q == IDW'(NREQ-1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = grant_q + IDW'(1);
        end
      end
      default: begin
        rr_ptr_d = '0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  // Outputs decoded from the state register only.
  always_comb begin
    ack  = '0;
    busy = (state_q != IDLE);
    if (state_q == RESP) begin
      ack[grant_q] = 1'b1;
    end else begin
      ack = '0;
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_adder_scheduler.sv
// Self-checking bench for adder_scheduler: transaction-level model plus directed scenarios.
module tb_adder_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 14;
  localparam int IDW  = $clog2(NREQ);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*DW-1:0]   a = '0;
  logic [NREQ*DW-1:0]   b = '0;
  logic [NREQ-1:0]      cin = '0;
  logic [NREQ-1:0]      ack;
  logic [DW-1:0]        sum;
  logic                 cout;
  logic [IDW-1:0]       grant_id;
  logic                 busy;

  int n_cmp = 0;
  int n_bad = 0;

  adder_scheduler #(.NREQ(NREQ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .ack      (ack),
    .sum      (sum),
    .cout     (cout),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (transaction level) ----------------
  longint          cyc = 0;
  longint          m_g = 0;
  bit              m_inflight = 1'b0;
  int              m_ptr = 0;
  int              m_id = 0;
  logic [DW-1:0]   m_sum = '0;
  logic            m_cout = 1'b0;
  logic [DW:0]     m_res = '0;

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  function automatic logic [DW:0] addv(input int i);
    return {1'b0, a[i*DW +: DW]} + {1'b0, b[i*DW +: DW]} + (DW+1)'(cin[i]);
  endfunction

  function automatic logic [NREQ-1:0] exp_ack();
    if (m_inflight && cyc == m_g + 1) return NREQ'(1) << m_id;
    return '0;
  endfunction

  // Grant at cycle G: busy for G and G+1, result visible from G+1, ack during G+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc        <= 0;
      m_g        <= 0;
      m_inflight <= 1'b0;
      m_ptr      <= 0;
      m_id       <= 0;
      m_sum      <= '0;
      m_cout     <= 1'b0;
      m_res      <= '0;
    end else begin
      cyc <= cyc + 1;
      if (m_inflight && cyc == m_g) begin
        m_sum  <= m_res[DW-1:0];
        m_cout <= m_res[DW];
      end
      if (m_inflight && cyc == m_g + 1) begin
        m_inflight <= 1'b0;
        m_ptr      <= (m_id + 1) % NREQ;
      end
      if (!m_inflight && req != '0) begin
        m_inflight <= 1'b1;
        m_g        <= cyc + 1;
        m_id       <= pick(req, m_ptr);
        m_res      <= addv(pick(req, m_ptr));
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    check("ack", 32'(ack), 32'(exp_ack()));
    check("busy", 32'(busy), 32'(m_inflight));
    check("grant_id", 32'(grant_id), 32'(m_id));
    check("sum", 32'(sum), 32'(m_sum));
    check("cout", 32'(cout), 32'(m_cout));
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_op(input int i, input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic c);
    a[i*DW +: DW] = av;
    b[i*DW +: DW] = bv;
    cin[i]        = c;
  endtask

  task automatic wait_ack(output int id, output longint t);
    id = -1;
    t  = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (ack != '0) begin
        for (int i = 0; i < NREQ; i++) begin
          if (ack[i]) id = i;
        end
        t = $time;
        return;
      end
    end
    check("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int     id;
    longint t, t0, tprev;
    int     exp_ord [5] = '{0, 1, 2, 3, 0};
    logic [DW:0] exp_res [4] = '{15'h0003, 15'h3001, 15'h4800, 15'h0BE0};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    rst_n = 1'b1;

    // Single requester, no carry: ack on third cycle.
    @(negedge clk); #1;
    set_op(0, 14'h2AAA, 14'h1555, 1'b0);
    req = 4'b0001;
    t0 = $time;
    wait_ack(id, t);
    check("r32_id", 32'(id), 32'd0);
    check("r32_latency", 32'(t - t0), 32'd20);
    check("r32_sum", 32'(sum), 32'h3FFF);
    check("r32_cout", 32'(cout), 32'd0);
    req = 4'b0000;

    // Carry-in pushes into overflow.
    @(negedge clk); #1;
    set_op(0, 14'h2AAA, 14'h1555, 1'b1);
    req = 4'b0001;
    wait_ack(id, t);
    check("r33a_sum", 32'(sum), 32'h0000);
    check("r33a_cout", 32'(cout), 32'd1);
    req = 4'b0000;

    @(negedge clk); #1;
    set_op(0, 14'h3FFF, 14'h0001, 1'b0);
    req = 4'b0001;
    wait_ack(id, t);
    check("r33b_sum", 32'(sum), 32'h0000);
    check("r33b_cout", 32'(cout), 32'd1);
    req = 4'b0000;

    // All four held continuously, from a fresh pointer.
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    set_op(0, 14'h0001, 14'h0002, 1'b0);
    set_op(1, 14'h1000, 14'h2000, 1'b1);
    set_op(2, 14'h3000, 14'h1800, 1'b0);
    set_op(3, 14'h0ABC, 14'h0123, 1'b1);
    req = 4'b1111;
    tprev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(id, t);
      check("r34_order", 32'(id), 32'(exp_ord[k]));
      check("r34_result", 32'({cout, sum}), 32'(exp_res[exp_ord[k]]));
      if (k > 0) check("r34_spacing", 32'(t - tprev), 32'd30);
      tprev = t;
    end
    req = 4'b0000;

    // Serve 2; 1 and 3 arrive meanwhile -> 3 then 1.
    @(negedge clk); #1;
    req = 4'b0100;
    @(negedge clk); #1;
    req = 4'b1110;
    wait_ack(id, t);
    check("r35_first", 32'(id), 32'd2);
    req[2] = 1'b0;
    wait_ack(id, t);
    check("r35_second", 32'(id), 32'd3);
    check("r35_sum3", 32'({cout, sum}), 32'h0BE0);
    req[3] = 1'b0;
    wait_ack(id, t);
    check("r35_third", 32'(id), 32'd1);
    check("r35_sum1", 32'({cout, sum}), 32'h3001);
    req[1] = 1'b0;

    // Operands change during ADD; latched values win.
    @(negedge clk); #1;
    set_op(0, 14'h0100, 14'h0200, 1'b0);
    req = 4'b0001;
    @(negedge clk); #1;
    set_op(0, 14'h3FFF, 14'h3FFF, 1'b1);
    wait_ack(id, t);
    check("r36_id", 32'(id), 32'd0);
    check("r36_result", 32'({cout, sum}), 32'h0300);
    req = 4'b0000;

    // Reset during ADD aborts; then req0 beats req2 from pointer 0.
    @(negedge clk); #1;
    set_op(0, 14'h0010, 14'h0020, 1'b0);
    req = 4'b0001;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("r37_ack", 32'(ack), 32'd0);
    check("r37_busy", 32'(busy), 32'd0);
    check("r37_sum", 32'(sum), 32'd0);
    check("r37_cout", 32'(cout), 32'd0);
    check("r37_gid", 32'(grant_id), 32'd0);
    set_op(0, 14'h0005, 14'h0007, 1'b0);
    req = 4'b0101;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_ack(id, t);
    check("r37_first", 32'(id), 32'd0);
    check("r37_sum0", 32'({cout, sum}), 32'h000C);
    req[0] = 1'b0;
    wait_ack(id, t);
    check("r37_second", 32'(id), 32'd2);
    check("r37_sum2", 32'({cout, sum}), 32'h4800);
    req = 4'b0000;

    repeat (3) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
